// File: rtl/interrupt_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer.
package interrupt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_D0,
    RST_D1,
    RST_D2,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_LO,
    VEC_HI,
    LOAD
  } seq_state_t;

  typedef enum logic [1:0] {
    IntReset,
    IntNmi,
    IntIrq
  } int_kind_t;

  // Status register bit positions touched when P is pushed
  localparam int unsigned STATUS_B_BIT = 4;
  localparam int unsigned STATUS_BIT5  = 5;

  // Default stack page and vector addresses
  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
  localparam logic [15:0] VEC_NMI_DEF    = 16'hFFFA;
  localparam logic [15:0] VEC_RESET_DEF  = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF    = 16'hFFFE;

  // P as written to the stack by a hardware interrupt: B cleared, bit5 set
  function automatic logic [7:0] push_status(input logic [7:0] p);
    return (p & ~(8'h01 << STATUS_B_BIT)) | (8'h01 << STATUS_BIT5);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous active-low request, with a
// one-cycle pulse on each synchronised 1->0 transition.
module edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus one delayed copy for edge detection; idle high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign fall_o  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset / NMI / IRQ entry sequencer. Takes the bus at an instruction
// boundary, pushes PCH, PCL and P, fetches the vector and hands it to the PC.
// Optional: INTERRUPT_SEQUENCER_NMI_HIJACK_EN lets an NMI that becomes
// pending during the pushes of an IRQ sequence redirect it to the NMI vector.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STACK_PAGE  = STACK_PAGE_DEF,
  parameter logic [15:0] VEC_NMI     = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RESET   = VEC_RESET_DEF,
  parameter logic [15:0] VEC_IRQ     = VEC_IRQ_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmib,
  input  logic        irqb,
  input  logic        irq_mask,
  input  logic        instr_boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] address_out,
  output logic [7:0]  data_out,
  output logic        read_write,
  output logic        sp_dec,
  output logic [15:0] vector_out,
  output logic        vector_valid,
  output logic        set_irq_mask
);

  seq_state_t state_q, state_d;
  int_kind_t  kind_q, kind_d;
  logic       nmi_pending_q, nmi_pending_d;
  logic [7:0] vec_lo_q;
  logic [15:0] vector_q;
  logic       vector_valid_q, set_mask_q, busy_q;
  logic       nmi_fall, irq_level, irq_fall_unused, irq_req;
  logic [15:0] vec_base;

  edge_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .async_i(nmib),
    .level_o(),
    .fall_o (nmi_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_i  (clk),
    .rst_i  (reset),
    .async_i(irqb),
    .level_o(irq_level),
    .fall_o (irq_fall_unused)
  );

  assign irq_req = ~irq_level & ~irq_mask;

  // Next state, latched interrupt kind and NMI pending flag
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    nmi_pending_d = nmi_pending_q;
    case (state_q)
      IDLE: begin
        if (instr_boundary && (nmi_pending_q || irq_req)) begin
          state_d = PUSH_PCH;
          if (nmi_pending_q) begin
            kind_d        = IntNmi;
            nmi_pending_d = 1'b0;
          end else begin
            kind_d = IntIrq;
          end
        end
      end
      RST_D0:   state_d = RST_D1;
      RST_D1:   state_d = RST_D2;
      RST_D2:   state_d = VEC_LO;
      PUSH_PCH: state_d = PUSH_PCL;
      PUSH_PCL: state_d = PUSH_P;
      PUSH_P: begin
        state_d = VEC_LO;
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
        // Redirect only the vector fetch; the pushed return data is already out
        if (kind_q == IntIrq && nmi_pending_q) begin
          kind_d        = IntNmi;
          nmi_pending_d = 1'b0;
        end
`endif
      end
      VEC_LO:   state_d = VEC_HI;
      VEC_HI:   state_d = LOAD;
      LOAD:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A fresh edge always wins over a same-cycle clear
    if (nmi_fall) nmi_pending_d = 1'b1;
  end

  // Sequencer state, vector capture and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RST_D0;
      kind_q         <= IntReset;
      nmi_pending_q  <= 1'b0;
      vec_lo_q       <= '0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
      set_mask_q     <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      nmi_pending_q  <= nmi_pending_d;
      if (state_q == VEC_LO) vec_lo_q <= data_in;
      if (state_q == VEC_HI) vector_q <= {data_in, vec_lo_q};
      vector_valid_q <= (state_d == LOAD);
      set_mask_q     <= (state_d == LOAD);
      busy_q         <= (state_d != IDLE);
    end
  end

  // Vector base address for the latched interrupt kind
  always_comb begin
    case (kind_q)
      IntNmi:  vec_base = VEC_NMI;
      IntIrq:  vec_base = VEC_IRQ;
      default: vec_base = VEC_RESET;
    endcase
  end

  // Bus drive; follows sp_in/pc_in live since the CPU updates them each cycle
  always_comb begin
    address_out = '0;
    data_out    = '0;
    read_write  = 1'b0;
    sp_dec      = 1'b0;
    if (!reset) begin
      case (state_q)
        RST_D0, RST_D1, RST_D2: begin
          address_out = {STACK_PAGE, sp_in};
          sp_dec      = 1'b1;
        end
        PUSH_PCH: begin
          address_out = {STACK_PAGE, sp_in};
          read_write  = 1'b1;
          sp_dec      = 1'b1;
          data_out    = pc_in[15:8];
        end
        PUSH_PCL: begin
          address_out = {STACK_PAGE, sp_in};
          read_write  = 1'b1;
          sp_dec      = 1'b1;
          data_out    = pc_in[7:0];
        end
        PUSH_P: begin
          address_out = {STACK_PAGE, sp_in};
          read_write  = 1'b1;
          sp_dec      = 1'b1;
          data_out    = push_status(status_in);
        end
        VEC_LO:  address_out = vec_base;
        VEC_HI:  address_out = vec_base + 16'd1;
        default: ;
      endcase
    end
  end

  assign busy         = busy_q;
  assign vector_out   = vector_q;
  assign vector_valid = vector_valid_q;
  assign set_irq_mask = set_mask_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: stimulus pushes expected bus
// cycles, a negedge monitor pops and compares every busy cycle.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset, nmib, irqb, irq_mask, instr_boundary;
  logic [15:0] pc_in;
  logic [7:0]  status_in, sp_in, data_in;
  logic        busy, read_write, sp_dec, vector_valid, set_irq_mask;
  logic [15:0] address_out, vector_out;
  logic [7:0]  data_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] addr;
    bit          chk_addr;
    bit          rw;
    logic [7:0]  data;
    bit          dec;
    bit          vv;
    logic [15:0] vec;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  interrupt_sequencer #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .nmib          (nmib),
    .irqb          (irqb),
    .irq_mask      (irq_mask),
    .instr_boundary(instr_boundary),
    .pc_in         (pc_in),
    .status_in     (status_in),
    .sp_in         (sp_in),
    .data_in       (data_in),
    .busy          (busy),
    .address_out   (address_out),
    .data_out      (data_out),
    .read_write    (read_write),
    .sp_dec        (sp_dec),
    .vector_out    (vector_out),
    .vector_valid  (vector_valid),
    .set_irq_mask  (set_irq_mask)
  );

  // Vector ROM
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h78;
      16'hFFFB: return 8'h56;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'hBC;
      16'hFFFF: return 8'h9A;
      default:  return 8'hEE;
    endcase
  endfunction

  assign data_in = mem_rd(address_out);

  // Stack pointer follows sp_dec like the CPU register would
  initial begin : sp_model
    bit dec_seen;
    forever begin
      @(negedge clk);
      dec_seen = sp_dec && !reset;
      @(posedge clk);
      #1;
      if (dec_seen) sp_in = sp_in - 8'd1;
    end
  end

  // Monitor: every busy cycle must match the head of the scoreboard
  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!reset && busy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_busy: busy=%b addr=%h rw=%b, required busy=0", busy, address_out, read_write);
        end else begin
          e  = exp_q.pop_front();
          ok = (read_write == e.rw) && (sp_dec == e.dec) && (vector_valid == e.vv) &&
               (set_irq_mask == e.vv) && (!e.chk_addr || address_out == e.addr) &&
               (!e.rw || data_out == e.data) && (!e.vv || vector_out == e.vec);
          if (!ok) begin
            fails++;
            $display("FAIL %s: got addr=%h rw=%b data=%h dec=%b vv=%b msk=%b vec=%h, expected addr=%h rw=%b data=%h dec=%b vv=%b msk=%b vec=%h",
                     e.tag, address_out, read_write, data_out, sp_dec, vector_valid, set_irq_mask, vector_out,
                     e.addr, e.rw, e.data, e.dec, e.vv, e.vv, e.vec);
          end
        end
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [15:0] a, input bit ca, input bit rw,
                          input logic [7:0] d, input bit dec, input bit vv, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.addr = a; e.chk_addr = ca; e.rw = rw;
    e.data = d; e.dec = dec; e.vv = vv; e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic push_int(input string tag, input logic [7:0] sp0, input logic [7:0] pch,
                          input logic [7:0] pcl, input logic [7:0] pbyte,
                          input logic [15:0] vaddr, input logic [15:0] vec);
    push_exp({tag, "_pch"}, {8'h01, sp0},         1, 1, pch,   1, 0, '0);
    push_exp({tag, "_pcl"}, {8'h01, sp0 - 8'd1},  1, 1, pcl,   1, 0, '0);
    push_exp({tag, "_p"},   {8'h01, sp0 - 8'd2},  1, 1, pbyte, 1, 0, '0);
    push_exp({tag, "_vlo"}, vaddr,                1, 0, '0,    0, 0, '0);
    push_exp({tag, "_vhi"}, vaddr + 16'd1,        1, 0, '0,    0, 0, '0);
    push_exp({tag, "_load"}, '0,                  0, 0, '0,    0, 1, vec);
  endtask

  task automatic push_reset(input string tag, input logic [7:0] sp0);
    push_exp({tag, "_d0"},  {8'h01, sp0},        1, 0, '0, 1, 0, '0);
    push_exp({tag, "_d1"},  {8'h01, sp0 - 8'd1}, 1, 0, '0, 1, 0, '0);
    push_exp({tag, "_d2"},  {8'h01, sp0 - 8'd2}, 1, 0, '0, 1, 0, '0);
    push_exp({tag, "_vlo"}, 16'hFFFC,            1, 0, '0, 0, 0, '0);
    push_exp({tag, "_vhi"}, 16'hFFFD,            1, 0, '0, 0, 0, '0);
    push_exp({tag, "_load"}, '0,                 0, 0, '0, 0, 1, 16'h1234);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_boundary();
    @(posedge clk);
    #1 instr_boundary = 1'b1;
    @(posedge clk);
    #1 instr_boundary = 1'b0;
  endtask

  // Wait (bounded) for the scoreboard to drain, then busy must be low next cycle
  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d cycles still outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    check1({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic expect_quiet(input string tag);
    repeat (4) @(negedge clk);
    #1;
    check1(tag, busy, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset = 1'b1; nmib = 1'b1; irqb = 1'b1; irq_mask = 1'b1; instr_boundary = 1'b0;
    pc_in = '0; status_in = '0; sp_in = 8'hFF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_busy", busy, 1'b1);
    check1("rst_rw", read_write, 1'b0);
    check1("rst_spdec", sp_dec, 1'b0);
    check1("rst_vv", vector_valid, 1'b0);
    check1("rst_mask", set_irq_mask, 1'b0);
    check16("rst_vec", vector_out, 16'h0000);
    check16("rst_dout", {8'h00, data_out}, 16'h0000);

    // Reset sequence
    push_reset("reset", 8'hFF);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_drain("reset");
    check16("reset_sp", {8'h00, sp_in}, 16'h00FC);

    // IRQ entry
    pc_in = 16'hC012; status_in = 8'hC3; sp_in = 8'hF0; irqb = 1'b0; irq_mask = 1'b0;
    tick(3);
    push_int("irq", 8'hF0, 8'hC0, 8'h12, 8'hE3, 16'hFFFE, 16'h9ABC);
    pulse_boundary();
    wait_drain("irq");
    check16("irq_vec_hold", vector_out, 16'h9ABC);

    // Masked IRQ
    irq_mask = 1'b1;
    pulse_boundary();
    expect_quiet("masked_idle");

    // IRQ released during PUSH_PCL still completes
    pc_in = 16'h8001; status_in = 8'h14; sp_in = 8'h80; irq_mask = 1'b0;
    tick(1);
    push_int("irq_rel", 8'h80, 8'h80, 8'h01, 8'h24, 16'hFFFE, 16'h9ABC);
    pulse_boundary();
    @(posedge clk);
    #1 irqb = 1'b1;
    wait_drain("irq_rel");
    irq_mask = 1'b1;

    // NMI beats IRQ, IRQ follows at the next boundary
    pc_in = 16'h4567; status_in = 8'h00; sp_in = 8'hA0; irqb = 1'b0; irq_mask = 1'b0; nmib = 1'b0;
    tick(5);
    push_int("nmi_pri", 8'hA0, 8'h45, 8'h67, 8'h20, 16'hFFFA, 16'h5678);
    pulse_boundary();
    wait_drain("nmi_pri");
    nmib = 1'b1;
    push_int("irq_after", 8'h9D, 8'h45, 8'h67, 8'h20, 16'hFFFE, 16'h9ABC);
    pulse_boundary();
    wait_drain("irq_after");
    irqb = 1'b1; irq_mask = 1'b1;
    tick(3);

    // NMI becomes pending during PUSH_PCL of an IRQ sequence
    pc_in = 16'h2468; status_in = 8'hFF; sp_in = 8'hC0; irqb = 1'b0; irq_mask = 1'b0;
    tick(3);
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    push_int("hijack", 8'hC0, 8'h24, 8'h68, 8'hEF, 16'hFFFA, 16'h5678);
`else
    push_int("hijack", 8'hC0, 8'h24, 8'h68, 8'hEF, 16'hFFFE, 16'h9ABC);
`endif
    @(posedge clk);
    #1 instr_boundary = 1'b1; nmib = 1'b0;
    @(posedge clk);
    #1 instr_boundary = 1'b0;
    wait_drain("hijack");
    irqb = 1'b1; irq_mask = 1'b1;
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    pulse_boundary();
    expect_quiet("no_second_nmi");
`else
    push_int("nmi_late", 8'hBD, 8'h24, 8'h68, 8'hEF, 16'hFFFA, 16'h5678);
    pulse_boundary();
    wait_drain("nmi_late");
`endif
    nmib = 1'b1;
    tick(3);

    // Reset asserted during VEC_LO aborts straight into the reset sequence
    pc_in = 16'h1111; status_in = 8'h00; sp_in = 8'h50; irqb = 1'b0; irq_mask = 1'b0;
    tick(3);
    push_exp("mid_pch", 16'h0150, 1, 1, 8'h11, 1, 0, '0);
    push_exp("mid_pcl", 16'h014F, 1, 1, 8'h11, 1, 0, '0);
    push_exp("mid_p",   16'h014E, 1, 1, 8'h20, 1, 0, '0);
    push_exp("mid_vlo", 16'hFFFE, 1, 0, 8'h00, 0, 0, '0);
    pulse_boundary();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1; irqb = 1'b1; irq_mask = 1'b1;
    #1;
    check1("mid_busy", busy, 1'b1);
    check1("mid_vv", vector_valid, 1'b0);
    check16("mid_vec_cleared", vector_out, 16'h0000);
    check16("mid_queue", 16'(exp_q.size()), 16'h0000);
    push_reset("reset2", 8'h4D);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_drain("reset2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
